// File: rtl/sword_pkg.sv
// Shared sword-game definitions: swing FSM states, saturating magnitude helper
// and the default swing thresholds also used by the game logic.
package sword_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } swing_state_t;

    localparam int DEFAULT_DATA_WIDTH       = 16;
    localparam int DEFAULT_THRESH_HI        = 200;
    localparam int DEFAULT_THRESH_LO        = 100;
    localparam int DEFAULT_MIN_SAMPLES      = 2;
    localparam int DEFAULT_MAX_SAMPLES      = 25;
    localparam int DEFAULT_COOLDOWN_SAMPLES = 10;

    // |v| clamped to the largest positive value of a w-bit signed number,
    // so the most-negative sample maps to full scale instead of wrapping.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v, input int unsigned w);
        logic [31:0] lim;
        logic [31:0] m;
        lim = (32'd1 << (w - 32'd1)) - 32'd1;
        if (v < 32'sd0) begin
            m = 32'(-v);
        end else begin
            m = 32'(v);
        end
        if (m > lim) begin
            m = lim;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/swing_detector_if.sv
// Sample stream in, swing events out; master = upstream/consumer side,
// slave = the swing detector.
interface swing_detector_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;
    logic                         swing_valid;
    logic                         swing_dir;
    logic [DATA_WIDTH-2:0]        swing_peak;
    logic [7:0]                   swing_len;
    logic [7:0]                   swing_count;
    logic                         busy;

    modport master (
        output sample_in, sample_valid,
        input  swing_valid, swing_dir, swing_peak, swing_len, swing_count, busy
    );

    modport slave (
        input  sample_in, sample_valid,
        output swing_valid, swing_dir, swing_peak, swing_len, swing_count, busy
    );
endinterface

// File: rtl/swing_detector.sv
// Hysteresis swing detector on the filtered X-axis stream: one registered
// event per completed swing with direction, peak magnitude and length.
module swing_detector
    import sword_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int THRESH_HI        = DEFAULT_THRESH_HI,
    parameter int THRESH_LO        = DEFAULT_THRESH_LO,
    parameter int MIN_SAMPLES      = DEFAULT_MIN_SAMPLES,
    parameter int MAX_SAMPLES      = DEFAULT_MAX_SAMPLES,
    parameter int COOLDOWN_SAMPLES = DEFAULT_COOLDOWN_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    swing_detector_if.slave  bus
);

    localparam logic [DATA_WIDTH-2:0] TH_HI_C = (DATA_WIDTH-1)'(THRESH_HI);
    localparam logic [DATA_WIDTH-2:0] TH_LO_C = (DATA_WIDTH-1)'(THRESH_LO);
    localparam logic [7:0]            MIN_C   = 8'(MIN_SAMPLES);
    localparam logic [7:0]            MAX_C   = 8'(MAX_SAMPLES);
    localparam logic [15:0]           CD_C    = 16'(COOLDOWN_SAMPLES);

    swing_state_t          state_q, state_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-2:0] peak_q, peak_d;
    logic [7:0]            len_q, len_d;
    logic [15:0]           cd_q, cd_d;

    logic                  swing_valid_q;
    logic                  swing_dir_q;
    logic [DATA_WIDTH-2:0] swing_peak_q;
    logic [7:0]            swing_len_q;
    logic [7:0]            swing_count_q;
    logic                  busy_q;

    logic [DATA_WIDTH-2:0] mag_s;
    logic                  sign_s;
    logic                  emit_s;
    logic                  enter_cd_s;

    assign mag_s  = (DATA_WIDTH-1)'(abs_sat(32'(bus.sample_in), DATA_WIDTH));
    assign sign_s = bus.sample_in[DATA_WIDTH-1];

    // Next-state logic; everything holds unless a valid sample arrives.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        peak_d     = peak_q;
        len_d      = len_q;
        cd_d       = cd_q;
        emit_s     = 1'b0;
        enter_cd_s = 1'b0;
        if (bus.sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (mag_s >= TH_HI_C) begin
                        state_d = ACTIVE;
                        dir_d   = sign_s;
                        peak_d  = mag_s;
                        len_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACTIVE: begin
                    if ((sign_s == dir_q) && (mag_s >= TH_LO_C)) begin
                        len_d = len_q + 8'd1;
                        if (mag_s > peak_q) begin
                            peak_d = mag_s;
                        end else begin
                            peak_d = peak_q;
                        end
                        // Too long to be a swing: treat as a hold and reject.
                        if (len_d == MAX_C) begin
                            enter_cd_s = 1'b1;
                        end else begin
                            enter_cd_s = 1'b0;
                        end
                    end else begin
                        if (len_q >= MIN_C) begin
                            emit_s     = 1'b1;
                            enter_cd_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                COOLDOWN: begin
                    if (cd_q <= 16'd1) begin
                        cd_d    = 16'd0;
                        state_d = IDLE;
                    end else begin
                        cd_d = cd_q - 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (enter_cd_s) begin
                if (CD_C == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = COOLDOWN;
                end
                cd_d = CD_C;
            end else begin
                cd_d = cd_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, latches and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dir_q         <= 1'b0;
            peak_q        <= '0;
            len_q         <= 8'd0;
            cd_q          <= 16'd0;
            swing_valid_q <= 1'b0;
            swing_dir_q   <= 1'b0;
            swing_peak_q  <= '0;
            swing_len_q   <= 8'd0;
            swing_count_q <= 8'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            peak_q        <= peak_d;
            len_q         <= len_d;
            cd_q          <= cd_d;
            swing_valid_q <= emit_s;
            busy_q        <= (state_d != IDLE);
            if (emit_s) begin
                swing_dir_q   <= dir_q;
                swing_peak_q  <= peak_q;
                swing_len_q   <= len_q;
                swing_count_q <= swing_count_q + 8'd1;
            end
        end
    end

    assign bus.swing_valid = swing_valid_q;
    assign bus.swing_dir   = swing_dir_q;
    assign bus.swing_peak  = swing_peak_q;
    assign bus.swing_len   = swing_len_q;
    assign bus.swing_count = swing_count_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_swing_detector.sv
// Directed bench for swing_detector: a queue-based swing model checked every
// cycle, plus literal expectations for each test-plan scenario.
module tb_swing_detector;

    localparam int DW   = 16;
    localparam int T_HI = 200;
    localparam int T_LO = 100;
    localparam int MINS = 2;
    localparam int MAXS = 25;
    localparam int CDS  = 10;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    swing_detector_if #(.DATA_WIDTH(DW)) bus ();

    swing_detector #(
        .DATA_WIDTH(DW), .THRESH_HI(T_HI), .THRESH_LO(T_LO),
        .MIN_SAMPLES(MINS), .MAX_SAMPLES(MAXS), .COOLDOWN_SAMPLES(CDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
        end
    endtask

    // Model: the current swing is a queue of magnitudes; cooldown is a count.
    int   run_q[$];
    bit   run_dir;
    int   cool;
    logic exp_valid, exp_dir, exp_busy;
    int   exp_peak, exp_len;
    logic [7:0] exp_cnt;

    function automatic int sat_mag(input int s);
        int m;
        m = (s < 0) ? -s : s;
        return (m > 32767) ? 32767 : m;
    endfunction

    task automatic model_step(input int s);
        int  m;
        bit  neg;
        int  pk;
        m   = sat_mag(s);
        neg = (s < 0);
        if (cool > 0) begin
            cool--;
        end else if (run_q.size() == 0) begin
            if (m >= T_HI) begin
                run_q.push_back(m);
                run_dir = neg;
            end
        end else if (neg == run_dir && m >= T_LO) begin
            run_q.push_back(m);
            if (run_q.size() == MAXS) begin
                run_q.delete();
                cool = CDS;
            end
        end else begin
            if (run_q.size() >= MINS) begin
                pk = 0;
                foreach (run_q[i]) if (run_q[i] > pk) pk = run_q[i];
                exp_valid = 1'b1;
                exp_dir   = run_dir;
                exp_peak  = pk;
                exp_len   = run_q.size();
                exp_cnt   = exp_cnt + 8'd1;
                cool      = CDS;
            end
            run_q.delete();
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            run_q.delete();
            run_dir   = 1'b0;
            cool      = 0;
            exp_valid = 1'b0;
            exp_dir   = 1'b0;
            exp_peak  = 0;
            exp_len   = 0;
            exp_cnt   = 8'd0;
            exp_busy  = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (bus.sample_valid) model_step(int'(bus.sample_in));
            exp_busy = (run_q.size() != 0) || (cool != 0);
        end
    end

    int         ev_seen = 0;
    logic       ev_dir;
    logic [14:0] ev_peak;
    logic [7:0] ev_len;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid", 32'(bus.swing_valid), 32'(exp_valid));
            chk("dir",   32'(bus.swing_dir),   32'(exp_dir));
            chk("peak",  32'(bus.swing_peak),  32'(exp_peak));
            chk("len",   32'(bus.swing_len),   32'(exp_len));
            chk("count", 32'(bus.swing_count), 32'(exp_cnt));
            chk("busy",  32'(bus.busy),        32'(exp_busy));
            if (bus.swing_valid === 1'b1) begin
                ev_seen++;
                ev_dir  = bus.swing_dir;
                ev_peak = bus.swing_peak;
                ev_len  = bus.swing_len;
            end
        end
    end

    // One strobe followed by two idle cycles; entered and left at posedge+1.
    task automatic send(input int v);
        bus.sample_in    = 16'(v);
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = 16'd0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    initial begin
        rst              = 1'b1;
        bus.sample_in    = 16'd0;
        bus.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.swing_count), 32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_valid", 32'(bus.swing_valid), 32'd0);

        // Positive swing, then two strong samples that cooldown must swallow.
        send(0); send(250); send(400); send(300); send(50);
        chk("pos_events", 32'(ev_seen), 32'd1);
        chk("pos_dir",    32'(ev_dir),  32'd0);
        chk("pos_peak",   32'(ev_peak), 32'd400);
        chk("pos_len",    32'(ev_len),  32'd3);
        chk("pos_count",  32'(bus.swing_count), 32'd1);
        chk("pos_busy",   32'(bus.busy), 32'd1);
        send(300); send(300); send_n(0, 7);
        chk("cd_busy9",   32'(bus.busy), 32'd1);
        send(0);
        chk("cd_busy10",  32'(bus.busy), 32'd0);
        chk("cd_noevent", 32'(ev_seen), 32'd1);

        // Negative swing including the saturating most-negative sample.
        send(-210); send(-32768); send(-150); send(-90);
        chk("neg_dir",   32'(ev_dir),  32'd1);
        chk("neg_peak",  32'(ev_peak), 32'd32767);
        chk("neg_len",   32'(ev_len),  32'd3);
        chk("neg_count", 32'(bus.swing_count), 32'd2);
        send_n(0, 10);

        // Too short, then a sign flip, then a minimal two-sample swing.
        send(250); send(50);
        chk("short_busy", 32'(bus.busy), 32'd0);
        send(250); send(-250);
        chk("flip_busy",  32'(bus.busy), 32'd0);
        chk("flip_noev",  32'(ev_seen),  32'd2);
        send(250); send(260); send(0);
        chk("min_len",   32'(ev_len),  32'd2);
        chk("min_peak",  32'(ev_peak), 32'd260);
        chk("min_count", 32'(bus.swing_count), 32'd3);
        send_n(0, 10);

        // Hold: rejected at 25 samples, then 10 cooldown samples.
        send_n(300, 25);
        chk("hold_busy25", 32'(bus.busy), 32'd1);
        send_n(300, 5); send_n(0, 4);
        chk("hold_busy34", 32'(bus.busy), 32'd1);
        send(0);
        chk("hold_busy35", 32'(bus.busy), 32'd0);
        chk("hold_noev",   32'(ev_seen),  32'd3);

        // Reset in the middle of a swing.
        send(250); send(300);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0); send(0);
        chk("mid_count", 32'(bus.swing_count), 32'd0);
        chk("mid_busy0", 32'(bus.busy), 32'd0);
        chk("mid_noev",  32'(ev_seen),  32'd3);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
